// File: rtl/axi_rd_arbiter.sv
// Two-port AXI3 read arbiter: round-robin grant, one outstanding burst, R beats
// routed back to the granted port with beat counting and sticky error detection.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [1:0]        rq_valid,
  input  logic [ADDR_W-1:0] rq_addr0,
  input  logic [ADDR_W-1:0] rq_addr1,
  input  logic [LEN_W-1:0]  rq_len0,
  input  logic [LEN_W-1:0]  rq_len1,
  input  logic [2:0]        rq_size0,
  input  logic [2:0]        rq_size1,
  output logic [1:0]        rq_ready,
  output logic [1:0]        rsp_valid,
  output logic              rsp_last,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic [3:0]        rid,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic                err_q, err_d;
  logic                win;
  logic                beat_bad;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      err_q        <= err_d;
    end
  end

  // Tie between both ports goes to the one not granted last time.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    err_d        = err_q;
    win          = 1'b0;
    beat_bad     = 1'b0;
    rq_ready     = 2'b00;
    rsp_valid    = 2'b00;
    rsp_last     = 1'b0;
    rsp_data     = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rq_valid != 2'b00) begin
          win          = (rq_valid == 2'b11) ? ~last_grant_q : rq_valid[1];
          grant_d      = win;
          last_grant_d = win;
          beat_cnt_d   = '0;
          addr_d       = win ? rq_addr1 : rq_addr0;
          len_d        = win ? rq_len1  : rq_len0;
          size_d       = win ? rq_size1 : rq_size0;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          rq_ready[grant_q] = 1'b1;
          state_d           = DATA;
        end
      end
      DATA: begin
        rready             = 1'b1;
        rsp_valid[grant_q] = rvalid;
        rsp_data           = rdata;
        rsp_last           = rlast;
        if (rvalid) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          beat_bad   = (rresp != 2'b00)
                     || (rlast && (beat_cnt_q != len_q))
                     || (!rlast && (beat_cnt_q == len_q))
                     || (rid != {3'b000, grant_q});
          if (beat_bad) begin
            err_d = 1'b1;
          end
          if (rlast) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arid    = {3'b000, grant_q};
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: a scripted AXI read slave plus an R-beat
// monitor checking routed beats against expectations queued with each request.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  logic              aclk;
  logic              areset;
  logic [1:0]        rq_valid;
  logic [ADDR_W-1:0] rq_addr0, rq_addr1;
  logic [LEN_W-1:0]  rq_len0, rq_len1;
  logic [2:0]        rq_size0, rq_size1;
  logic [1:0]        rq_ready;
  logic [1:0]        rsp_valid;
  logic              rsp_last;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [3:0]        rid;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              busy;
  logic              err;

  typedef struct packed {
    logic [1:0]        port;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  typedef struct packed {
    logic [3:0]        rid;
    logic [DATA_W-1:0] base;
    logic [4:0]        last_at;
    logic              bad_resp_en;
    logic [4:0]        bad_resp_at;
    logic              bad_rid;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  plan_t act_q[$];
  int    beat_idx;
  bit    ar_hs, r_hs;
  int    errors, checks;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .aclk(aclk), .areset(areset),
    .rq_valid(rq_valid), .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_len0(rq_len0), .rq_len1(rq_len1), .rq_size0(rq_size0), .rq_size1(rq_size1),
    .rq_ready(rq_ready), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .busy(busy), .err(err)
  );

  initial aclk = 1'b0;
  always #10 aclk = ~aclk;

  // Inputs move at negedge+3, so everything is stable across the posedge at +10.
  task automatic tick();
    @(negedge aclk);
    #3;
  endtask

  task automatic flush();
    plan_q.delete();
    act_q.delete();
    exp_q.delete();
    beat_idx = 0;
    ar_hs    = 1'b0;
    r_hs     = 1'b0;
    rq_valid = 2'b00;
    arready  = 1'b1;
  endtask

  // Handshakes recorded at +5 are applied at the next negedge+1.
  task automatic slave();
    forever begin
      @(negedge aclk);
      #1;
      if (ar_hs && plan_q.size() > 0) act_q.push_back(plan_q.pop_front());
      if (r_hs && act_q.size() > 0) begin
        if (5'(beat_idx) == act_q[0].last_at) begin
          void'(act_q.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      if (act_q.size() > 0) begin
        rvalid = 1'b1;
        rdata  = act_q[0].base + DATA_W'(beat_idx);
        rlast  = (5'(beat_idx) == act_q[0].last_at);
        rresp  = (act_q[0].bad_resp_en && 5'(beat_idx) == act_q[0].bad_resp_at) ? 2'b10 : 2'b00;
        rid    = (act_q[0].bad_rid && beat_idx == 0) ? ~act_q[0].rid : act_q[0].rid;
      end else begin
        rvalid = 1'b0;
        rdata  = '0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rid    = 4'h0;
      end
      #4;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge aclk);
      #2;
      if (rsp_valid !== 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: rsp_valid=%b data=%h last=%b, required no beat",
                   rsp_valid, rsp_data, rsp_last);
        end else begin
          e = exp_q.pop_front();
          if (rsp_valid !== e.port || rsp_data !== e.data || rsp_last !== e.last) begin
            errors++;
            $display("FAIL beat: got valid=%b data=%h last=%b, required valid=%b data=%h last=%b",
                     rsp_valid, rsp_data, rsp_last, e.port, e.data, e.last);
          end
        end
      end
    end
  endtask

  task automatic push_txn(input int port, input logic [DATA_W-1:0] base, input logic [4:0] last_at,
                          input bit bad_resp_en, input logic [4:0] bad_resp_at, input bit bad_rid);
    plan_t p;
    exp_t  e;
    p.rid         = 4'(port);
    p.base        = base;
    p.last_at     = last_at;
    p.bad_resp_en = bad_resp_en;
    p.bad_resp_at = bad_resp_at;
    p.bad_rid     = bad_rid;
    plan_q.push_back(p);
    for (int i = 0; i <= int'(last_at); i++) begin
      e.port = (port == 0) ? 2'b01 : 2'b10;
      e.data = base + DATA_W'(i);
      e.last = (i == int'(last_at));
      exp_q.push_back(e);
    end
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    flush();
    repeat (2) tick();
    areset = 1'b0;
    tick();
  endtask

  task automatic wait_grant(input int port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rq_ready[port]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout: port %0d rq_ready=%b, required a pulse", port, rq_ready);
    end
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done: busy=%b pending_beats=%0d, required idle with 0 pending",
               name, busy, exp_q.size());
    end
  endtask

  task automatic run_txn(input int port, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                         input logic [DATA_W-1:0] base, input logic [4:0] last_at,
                         input bit bad_resp_en, input logic [4:0] bad_resp_at, input bit bad_rid);
    bit ok;
    push_txn(port, base, last_at, bad_resp_en, bad_resp_at, bad_rid);
    if (port == 0) begin
      rq_addr0 = addr; rq_len0 = len; rq_size0 = 3'd2;
    end else begin
      rq_addr1 = addr; rq_len1 = len; rq_size1 = 3'd2;
    end
    rq_valid[port] = 1'b1;
    wait_grant(port, ok);
    rq_valid[port] = 1'b0;
    wait_done("txn");
  endtask

  task automatic test_reset();
    areset = 1'b1;
    flush();
    #1;
    checks++;
    if ({arvalid, rready, rq_ready, rsp_valid, busy, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: arvalid=%b rready=%b rq_ready=%b rsp_valid=%b busy=%b err=%b, required all 0",
               arvalid, rready, rq_ready, rsp_valid, busy, err);
    end
    checks++;
    if (araddr !== '0 || arlen !== '0 || arsize !== 3'd0 || arid !== 4'd0) begin
      errors++;
      $display("FAIL reset_ar: araddr=%h arlen=%h arsize=%h arid=%h, required all 0", araddr, arlen, arsize, arid);
    end
    checks++;
    if (arburst !== 2'b01) begin
      errors++;
      $display("FAIL arburst: got %b, required 01", arburst);
    end
    repeat (2) tick();
    areset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b arvalid=%b, required 0 0", busy, arvalid);
    end
  endtask

  task automatic test_single();
    apply_reset();
    push_txn(0, 32'hA0, 5'd3, 1'b0, 5'd0, 1'b0);
    rq_addr0 = 32'h1FC0_0000; rq_len0 = 4'd3; rq_size0 = 3'd2;
    rq_valid = 2'b01;
    #1;
    checks++;
    if (arvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_arvalid: got %b, required 0", arvalid);
    end
    tick();
    checks++;
    if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1FC0_0000 || arlen !== 4'd3 || arsize !== 3'd2) begin
      errors++;
      $display("FAIL single_ar: arvalid=%b arid=%h araddr=%h arlen=%h arsize=%h, required 1 0 1fc00000 3 2",
               arvalid, arid, araddr, arlen, arsize);
    end
    checks++;
    if (rq_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_rq_ready: got %b, required 01", rq_ready);
    end
    rq_valid = 2'b00;
    tick();
    checks++;
    if (rq_ready !== 2'b00 || rready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_data_phase: rq_ready=%b rready=%b busy=%b, required 00 1 1", rq_ready, rready, busy);
    end
    wait_done("single");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL single_err: got %b, required 0", err);
    end
  endtask

  task automatic test_tie();
    bit found;
    apply_reset();
    push_txn(0, 32'hB0, 5'd1, 1'b0, 5'd0, 1'b0);
    push_txn(1, 32'hE0, 5'd0, 1'b0, 5'd0, 1'b0);
    rq_addr0 = 32'h0000_1000; rq_len0 = 4'd1; rq_size0 = 3'd2;
    rq_addr1 = 32'h8000_0100; rq_len1 = 4'd0; rq_size1 = 3'd2;
    rq_valid = 2'b11;
    tick();
    checks++;
    if (arid !== 4'd0 || rq_ready !== 2'b01) begin
      errors++;
      $display("FAIL tie_first: arid=%h rq_ready=%b, required 0 01", arid, rq_ready);
    end
    rq_valid[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rsp_valid[0] && rsp_last) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tie_last_timeout: rsp_valid=%b rsp_last=%b, required port0 last beat", rsp_valid, rsp_last);
    end
    tick();
    checks++;
    if (arvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_gap: arvalid=%b busy=%b, required 0 0", arvalid, busy);
    end
    tick();
    checks++;
    if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h8000_0100 || arlen !== 4'd0 || rq_ready !== 2'b10) begin
      errors++;
      $display("FAIL tie_second: arvalid=%b arid=%h araddr=%h arlen=%h rq_ready=%b, required 1 1 80000100 0 10",
               arvalid, arid, araddr, arlen, rq_ready);
    end
    rq_valid[1] = 1'b0;
    wait_done("tie");
  endtask

  task automatic test_fairness();
    int exp_order[4];
    int n;
    exp_order = '{0, 1, 0, 1};
    apply_reset();
    push_txn(0, 32'hC0, 5'd0, 1'b0, 5'd0, 1'b0);
    push_txn(1, 32'hD0, 5'd1, 1'b0, 5'd0, 1'b0);
    push_txn(0, 32'hC8, 5'd0, 1'b0, 5'd0, 1'b0);
    push_txn(1, 32'hD8, 5'd1, 1'b0, 5'd0, 1'b0);
    rq_addr0 = 32'h0000_2000; rq_len0 = 4'd0; rq_size0 = 3'd2;
    rq_addr1 = 32'h0000_3000; rq_len1 = 4'd1; rq_size1 = 3'd2;
    rq_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      tick();
      if (rq_ready != 2'b00) begin
        checks++;
        if (rq_ready !== ((exp_order[n] == 0) ? 2'b01 : 2'b10) || arid !== 4'(exp_order[n])) begin
          errors++;
          $display("FAIL fair_grant%0d: rq_ready=%b arid=%h, required port %0d", n, rq_ready, arid, exp_order[n]);
        end
        n++;
        if (n == 4) rq_valid = 2'b00;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL fair_count: got %0d grants, required 4", n);
    end
    rq_valid = 2'b00;
    wait_done("fair");
  endtask

  task automatic test_ar_stall();
    apply_reset();
    arready = 1'b0;
    push_txn(1, 32'hF0, 5'd0, 1'b0, 5'd0, 1'b0);
    rq_addr1 = 32'h0000_4440; rq_len1 = 4'd0; rq_size1 = 3'd2;
    rq_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h0000_4440 || rq_ready !== 2'b00) begin
        errors++;
        $display("FAIL stall_cycle%0d: arvalid=%b araddr=%h rq_ready=%b, required 1 00004440 00",
                 i, arvalid, araddr, rq_ready);
      end
      tick();
    end
    arready = 1'b1;
    #1;
    checks++;
    if (rq_ready !== 2'b10) begin
      errors++;
      $display("FAIL stall_release: rq_ready=%b, required 10", rq_ready);
    end
    rq_valid = 2'b00;
    wait_done("stall");
  endtask

  task automatic test_errors();
    // Early rlast
    apply_reset();
    run_txn(0, 32'h0000_5000, 4'd3, 32'h10, 5'd2, 1'b0, 5'd0, 1'b0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_early_last: err=%b busy=%b, required 1 0", err, busy);
    end
    // Bad rresp stays sticky
    apply_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b, required 0", err);
    end
    run_txn(1, 32'h0000_6000, 4'd1, 32'h20, 5'd1, 1'b1, 5'd1, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_rresp: got %b, required 1", err);
    end
    run_txn(0, 32'h0000_6100, 4'd0, 32'h30, 5'd0, 1'b0, 5'd0, 1'b0);
    run_txn(1, 32'h0000_6200, 4'd1, 32'h38, 5'd1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    // rid mismatch
    apply_reset();
    run_txn(1, 32'h0000_7000, 4'd0, 32'h40, 5'd0, 1'b0, 5'd0, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_rid: got %b, required 1", err);
    end
    // Missing rlast: arbiter waits in DATA for the late rlast
    apply_reset();
    run_txn(0, 32'h0000_7100, 4'd1, 32'h48, 5'd2, 1'b0, 5'd0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_late_last: got %b, required 1", err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    apply_reset();
    push_txn(0, 32'h50, 5'd3, 1'b0, 5'd0, 1'b0);
    rq_addr0 = 32'h0000_8000; rq_len0 = 4'd3; rq_size0 = 3'd2;
    rq_valid = 2'b01;
    wait_grant(0, ok);
    rq_valid = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rsp_valid[0] && rsp_data == 32'h51) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_beat1_timeout: rsp_valid=%b data=%h, required beat 51", rsp_valid, rsp_data);
    end
    #3;
    areset = 1'b1;
    #1;
    checks++;
    if ({arvalid, rready, rq_ready, rsp_valid, busy, err, rsp_last} !== 9'h000) begin
      errors++;
      $display("FAIL midreset_ctrl: arvalid=%b rready=%b rq_ready=%b rsp_valid=%b busy=%b err=%b rsp_last=%b, required all 0",
               arvalid, rready, rq_ready, rsp_valid, busy, err, rsp_last);
    end
    checks++;
    if (araddr !== '0 || arlen !== '0 || arsize !== 3'd0 || arid !== 4'd0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL midreset_data: araddr=%h arlen=%h arsize=%h arid=%h rsp_data=%h, required all 0",
               araddr, arlen, arsize, arid, rsp_data);
    end
    flush();
    repeat (2) tick();
    areset = 1'b0;
    tick();
    run_txn(1, 32'h0000_9000, 4'd1, 32'h60, 5'd1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_recover: err=%b busy=%b, required 0 0", err, busy);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    areset   = 1'b1;
    rq_addr0 = '0; rq_addr1 = '0;
    rq_len0  = '0; rq_len1  = '0;
    rq_size0 = 3'd0; rq_size1 = 3'd0;
    rvalid   = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00; rid = 4'h0;
    flush();
    fork
      slave();
      monitor();
    join_none
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_ar_stall();
    test_errors();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats: %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI3 read-address/read-data channel pair between two requesters: port 0 = i-cache, port 1 = d-cache.
- Grants with round-robin priority and keeps at most one read outstanding at a time.
- Latches the winning request and routes R beats back to the winner.
- Counts beats against the granted burst length and flags protocol errors.
- Sits between the cache controllers and the top-level AXI crossbar. The write channel bypasses this block.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 4, AXI3 burst length field width (beats = len+1)

Ports:
- aclk  in  1  clock
- areset  in  1  reset; asynchronous, active-high
- rq_valid  in  2  request valid per port (bit0 icache, bit1 dcache)
- rq_addr0 / rq_addr1  in  ADDR_W  request address per port
- rq_len0 / rq_len1  in  LEN_W  burst length-1 per port
- rq_size0 / rq_size1  in  3  beat size per port
- rq_ready  out  2  one-cycle pulse to a port when its AR handshake completes
- rsp_valid  out  2  R beat valid, routed to the granted port
- rsp_last  out  1  last beat of the burst (shared)
- rsp_data  out  DATA_W  R beat data (shared)
- arid  out  4  {3'b0, grant}
- araddr  out  ADDR_W  latched request address
- arlen  out  LEN_W  latched burst length
- arsize  out  3  latched beat size
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  address valid
- arready  in  1  address ready
- rdata  in  DATA_W  read data
- rresp  in  2  read response
- rlast  in  1  last beat
- rvalid  in  1  beat valid
- rready  out  1  beat ready
- busy  out  1  state != IDLE
- err  out  1  sticky error flag

Behaviour:
- Reset values:
  - state = IDLE
  - arvalid = 0, rready = 0, rq_ready = 0, rsp_valid = 0, busy = 0, err = 0
  - araddr / arlen / arsize / arid = 0
  - last_grant = 1, so port 0 wins the first tie
  - beat_cnt = 0
- Reset asserted mid-transfer returns to IDLE immediately and drops all outputs to the reset values. In-flight AXI beats are not tracked.
- States:
  - IDLE: no transaction in progress.
  - ADDR: arvalid = 1; araddr / arlen / arsize / arid held stable from the latched registers.
  - DATA: rready = 1.
- IDLE -> ADDR:
  - Taken on the first edge where any rq_valid bit is 1.
  - Grant rule: single requester wins outright; if both are valid, the port != last_grant wins.
  - On that edge: latch the winner's addr/len/size, set grant, update last_grant, clear beat_cnt.
  - arvalid rises in the cycle after the request is sampled, giving 1 cycle request-to-arvalid latency.
- ADDR -> DATA:
  - Taken on the edge where arvalid & arready.
  - rq_ready[grant] = 1 combinationally in that cycle only.
  - The requester holds rq_valid and its fields stable until it sees rq_ready.
  - rq_valid dropping before the handshake is illegal and is not checked.
- In DATA:
  - rsp_valid[grant] = rvalid, combinational pass-through.
  - rsp_data = rdata, rsp_last = rlast.
  - rsp_valid of the non-granted port stays 0.
  - beat_cnt increments on each rvalid & rready.
- DATA -> IDLE:
  - Taken on the edge where rvalid & rready & rlast.
  - A new grant can be made in the next cycle, so a requester waiting in IDLE reaches arvalid 2 cycles after the last beat.
- err (sticky until reset) is set on any of these beat handshakes:
  - rresp != 2'b00
  - rlast = 1 while beat_cnt != arlen
  - beat_cnt == arlen while rlast = 0; the arbiter stays in DATA until rlast arrives
  - rid != arid; the beat is still routed by the latched grant
- Other requester: a request arriving while the arbiter is busy waits and is not dropped. Fairness: with both ports requesting continuously, grants alternate 0, 1, 0, 1.
- Edge cases:
  - arlen = 0 is a single-beat burst. rlast on the first beat returns to IDLE with no error.
  - beat_cnt is LEN_W bits wide and does not wrap in legal traffic (max 16 beats).

Test Plan:
1. Port 0 alone: rq_addr0=0x1FC0_0000, rq_len0=3, arready=1 → arvalid 1 cycle after request, arid=0, rq_ready[0] pulses; 4 beats 0xA0..0xA3 appear on rsp_valid[0] only; busy falls after the 4th (rlast) beat; err=0.
2. Both ports request in the same cycle from reset → port 0 granted first; port 1 (rq_addr1=0x8000_0100, rq_len1=0) granted 2 cycles after port 0's rlast; arid=1; the single beat goes to rsp_valid[1].
3. Both ports request continuously for 4 transactions → grant order 0, 1, 0, 1.
4. arready held 0 for 5 cycles → arvalid stays 1 with araddr stable; rq_ready stays 0 until the handshake.
5. Error cases:
   - arlen=3 with rlast on beat 2 → err=1, return to IDLE.
   - Separate run: rresp=2'b10 on one beat → err=1, still set after two further transactions.
6. areset pulsed during DATA (beat 1 of 4) → state IDLE and all outputs 0 asynchronously; a fresh port 1 request afterwards completes normally.
